// File: rtl/rcp_arbiter.sv
// Arbitrates a single combinational reciprocal unit between NUM_REQ requesters.
// Define RCP_ARB_FIXED_PRIO_EN for fixed lowest-index priority; round-robin otherwise.
module rcp_arbiter #(
    parameter int NUM_REQ       = 3,
    parameter int DATA_W        = 24,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        flush,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          done,
    output logic [DATA_W-1:0]           result,
    output logic                        result_sat,
    output logic                        busy,
    output logic [DATA_W-1:0]           rcp_in,
    input  logic [DATA_W-1:0]           rcp_out,
    input  logic                        rcp_sat
);

    localparam int SEL_W = $clog2(NUM_REQ);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } stateT;

    stateT               state;
    logic [CNT_W-1:0]    cnt;
    logic [SEL_W-1:0]    sel;
    logic [SEL_W-1:0]    winner;
    logic [NUM_REQ-1:0]  winOneHot;
    logic [NUM_REQ-1:0]  selOneHot;
    logic                anyReq;
    logic [DATA_W-1:0]   lane [NUM_REQ];

`ifndef RCP_ARB_FIXED_PRIO_EN
    logic [SEL_W-1:0]    last;
    logic                found;
`endif

    for (genvar g = 0; g < NUM_REQ; g++) begin : gLane
        assign lane[g] = req_data[g*DATA_W +: DATA_W];
    end

    // Winner selection: round-robin scans indices above last first, then wraps to the rest.
    always_comb begin
        anyReq    = |req;
        winner    = '0;
        winOneHot = '0;
`ifdef RCP_ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = SEL_W'(i);
            end
        end
`else
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i > int'(last))) begin
                winner = SEL_W'(i);
                found  = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i <= int'(last))) begin
                winner = SEL_W'(i);
                found  = 1'b1;
            end
        end
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            winOneHot[i] = (winner == SEL_W'(i));
        end
    end

    always_comb begin
        selOneHot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            selOneHot[i] = (sel == SEL_W'(i));
        end
    end

    // Operand is parked at zero outside an active transaction so the reciprocal stays quiet.
    always_comb begin
        rcp_in = '0;
        if ((state == SETTLE) || (state == CAPTURE)) begin
            rcp_in = lane[sel];
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            gnt        <= '0;
            done       <= '0;
            result     <= '0;
            result_sat <= 1'b0;
            cnt        <= '0;
            sel        <= '0;
`ifndef RCP_ARB_FIXED_PRIO_EN
            last       <= SEL_W'(NUM_REQ - 1);
`endif
        end else if (flush && (state != IDLE)) begin
            // Abort wins over capture; the previous result is deliberately kept.
            state <= IDLE;
            gnt   <= '0;
            done  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= '0;
                    if (!flush && anyReq) begin
                        sel   <= winner;
                        gnt   <= winOneHot;
                        cnt   <= CNT_W'(SETTLE_CYCLES - 1);
`ifndef RCP_ARB_FIXED_PRIO_EN
                        last  <= winner;
`endif
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    result     <= rcp_out;
                    result_sat <= rcp_sat;
                    done       <= selOneHot;
                    state      <= DONE;
                end
                DONE: begin
                    // Extra cycle gives a registered requester time to drop req.
                    done  <= '0;
                    gnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rcp_arbiter.sv
// Directed testbench for rcp_arbiter with a behavioural Q12.12 reciprocal model.
module tb_rcp_arbiter;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic [2:0]  req;
    logic [71:0] req_data;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic [23:0] result;
    logic        result_sat;
    logic        busy;
    logic [23:0] rcp_in;
    logic [23:0] rcp_out;
    logic        rcp_sat;
    logic [47:0] quot;

    int checkCount = 0;
    int passCount  = 0;
    logic [23:0] priorResult;

    rcp_arbiter #(
        .NUM_REQ(3),
        .DATA_W(24),
        .SETTLE_CYCLES(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .flush(flush),
        .req(req),
        .req_data(req_data),
        .gnt(gnt),
        .done(done),
        .result(result),
        .result_sat(result_sat),
        .busy(busy),
        .rcp_in(rcp_in),
        .rcp_out(rcp_out),
        .rcp_sat(rcp_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference reciprocal: 1/x in Q12.12, saturating at the largest positive value.
    always_comb begin
        quot    = '0;
        rcp_out = '0;
        rcp_sat = 1'b0;
        if (rcp_in == 24'h0) begin
            rcp_out = 24'h7FFFFF;
            rcp_sat = 1'b1;
        end else begin
            quot = 48'h1000000 / {24'h0, rcp_in};
            if (quot > 48'h7FFFFF) begin
                rcp_out = 24'h7FFFFF;
                rcp_sat = 1'b1;
            end else begin
                rcp_out = quot[23:0];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic waitGrant(output int who, output int waited);
        who    = -1;
        waited = 0;
        for (int n = 0; (n < 12) && (who < 0); n++) begin
            tick();
            waited++;
            for (int i = 0; i < 3; i++) begin
                if (gnt[i]) who = i;
            end
        end
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        flush    = 1'b0;
        req      = 3'b000;
        req_data = '0;
        repeat (2) @(negedge clk);
        checkCount++; if (gnt !== 3'b000) $display("[TB] FAIL reset_gnt got %b expected 000", gnt); else passCount++;
        checkCount++; if (done !== 3'b000) $display("[TB] FAIL reset_done got %b expected 000", done); else passCount++;
        checkCount++; if (result !== 24'h0 || result_sat !== 1'b0) $display("[TB] FAIL reset_result got %h/%b expected 000000/0", result, result_sat); else passCount++;
        checkCount++; if (busy !== 1'b0 || rcp_in !== 24'h0) $display("[TB] FAIL reset_busy got %b/%h expected 0/000000", busy, rcp_in); else passCount++;
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        req_data[23:0] = 24'h002000;
        req = 3'b001;
        tick();
        checkCount++; if (gnt !== 3'b001 || busy !== 1'b1) $display("[TB] FAIL single_grant got %b/%b expected 001/1", gnt, busy); else passCount++;
        checkCount++; if (rcp_in !== 24'h002000) $display("[TB] FAIL single_rcp_in got %h expected 002000", rcp_in); else passCount++;
        tick();
        tick();
        checkCount++; if (done !== 3'b000 || gnt !== 3'b001) $display("[TB] FAIL single_early_done got %b/%b expected 000/001", done, gnt); else passCount++;
        tick();
        checkCount++; if (done !== 3'b001 || gnt !== 3'b001) $display("[TB] FAIL single_done got %b/%b expected 001/001", done, gnt); else passCount++;
        checkCount++; if (result !== 24'h000800 || result_sat !== 1'b0) $display("[TB] FAIL single_result got %h/%b expected 000800/0", result, result_sat); else passCount++;
        req = 3'b000;
        tick();
        checkCount++; if (done !== 3'b000 || gnt !== 3'b000 || busy !== 1'b0) $display("[TB] FAIL single_release got %b/%b/%b expected 000/000/0", done, gnt, busy); else passCount++;
    endtask

    task automatic test_contention();
        int who;
        int waited;
        int expWho[3]          = '{0, 1, 2};
        logic [23:0] expRes[3] = '{24'h001000, 24'h000400, 24'h002000};
        doReset();
        req_data = {24'h000800, 24'h004000, 24'h001000};
        req = 3'b111;
        for (int j = 0; j < 3; j++) begin
            waitGrant(who, waited);
            checkCount++; if (who !== expWho[j]) $display("[TB] FAIL contention_order%0d got %0d expected %0d", j, who, expWho[j]); else passCount++;
            checkCount++; if (waited !== 1 || !$onehot(gnt)) $display("[TB] FAIL contention_spacing%0d got wait %0d gnt %b expected wait 1 one-hot", j, waited, gnt); else passCount++;
            repeat (3) tick();
            checkCount++; if (done !== (3'b001 << expWho[j]) || result !== expRes[j]) $display("[TB] FAIL contention_done%0d got %b/%h expected %b/%h", j, done, result, 3'b001 << expWho[j], expRes[j]); else passCount++;
            tick();
            checkCount++; if (done !== 3'b000 || gnt !== 3'b000) $display("[TB] FAIL contention_pulse%0d got %b/%b expected 000/000", j, done, gnt); else passCount++;
            req[expWho[j]] = 1'b0;
        end
    endtask

    task automatic test_fairness();
        int who;
        int waited;
`ifdef RCP_ARB_FIXED_PRIO_EN
        int expWho[4] = '{0, 0, 0, 0};
        priorResult   = 24'h001000;
`else
        int expWho[4] = '{0, 2, 0, 2};
        priorResult   = 24'h002000;
`endif
        req = 3'b101;
        for (int j = 0; j < 4; j++) begin
            waitGrant(who, waited);
            checkCount++; if (who !== expWho[j] || waited !== 1) $display("[TB] FAIL fairness_grant%0d got %0d after %0d expected %0d after 1", j, who, waited, expWho[j]); else passCount++;
            repeat (4) tick();
        end
        req = 3'b000;
        checkCount++; if (result !== priorResult) $display("[TB] FAIL fairness_result got %h expected %h", result, priorResult); else passCount++;
    endtask

    task automatic test_flush();
        logic sawDone;
        req = 3'b010;
        tick();
        checkCount++; if (gnt !== 3'b010) $display("[TB] FAIL flush_grant got %b expected 010", gnt); else passCount++;
        flush = 1'b1;
        tick();
        checkCount++; if (gnt !== 3'b000 || busy !== 1'b0 || done !== 3'b000) $display("[TB] FAIL flush_settle got %b/%b/%b expected 000/0/000", gnt, busy, done); else passCount++;
        checkCount++; if (result !== priorResult) $display("[TB] FAIL flush_result got %h expected %h", result, priorResult); else passCount++;
        flush = 1'b0;
        req = 3'b000;
        sawDone = 1'b0;
        repeat (3) begin
            tick();
            if (done !== 3'b000) sawDone = 1'b1;
        end
        checkCount++; if (sawDone !== 1'b0) $display("[TB] FAIL flush_no_done got %b expected 0", sawDone); else passCount++;
        flush = 1'b1;
        req = 3'b001;
        tick();
        checkCount++; if (gnt !== 3'b000 || busy !== 1'b0) $display("[TB] FAIL flush_idle got %b/%b expected 000/0", gnt, busy); else passCount++;
        flush = 1'b0;
        req = 3'b010;
        repeat (3) tick();
        flush = 1'b1;
        tick();
        checkCount++; if (done !== 3'b000 || busy !== 1'b0 || gnt !== 3'b000) $display("[TB] FAIL flush_capture got %b/%b/%b expected 000/0/000", done, busy, gnt); else passCount++;
        checkCount++; if (result !== priorResult) $display("[TB] FAIL flush_capture_result got %h expected %h", result, priorResult); else passCount++;
        flush = 1'b0;
        req = 3'b000;
        tick();
    endtask

    task automatic test_async_reset();
        int who;
        int waited;
        req = 3'b100;
        tick();
        checkCount++; if (gnt !== 3'b100) $display("[TB] FAIL areset_grant got %b expected 100", gnt); else passCount++;
        repeat (2) tick();
        #1 reset_n = 1'b0;
        #1;
        checkCount++; if (gnt !== 3'b000 || done !== 3'b000 || busy !== 1'b0) $display("[TB] FAIL areset_ctrl got %b/%b/%b expected 000/000/0", gnt, done, busy); else passCount++;
        checkCount++; if (result !== 24'h0 || result_sat !== 1'b0 || rcp_in !== 24'h0) $display("[TB] FAIL areset_data got %h/%b/%h expected 000000/0/000000", result, result_sat, rcp_in); else passCount++;
        req = 3'b101;
        #1 reset_n = 1'b1;
        waitGrant(who, waited);
        checkCount++; if (who !== 0) $display("[TB] FAIL areset_first_grant got %0d expected 0", who); else passCount++;
        repeat (3) tick();
        checkCount++; if (done !== 3'b001 || result !== 24'h001000) $display("[TB] FAIL areset_done got %b/%h expected 001/001000", done, result); else passCount++;
        req = 3'b000;
        tick();
    endtask

    task automatic test_saturation();
        int who;
        int waited;
        req_data[23:0] = 24'h000000;
        req = 3'b001;
        waitGrant(who, waited);
        checkCount++; if (who !== 0) $display("[TB] FAIL sat_grant got %0d expected 0", who); else passCount++;
        repeat (3) tick();
        checkCount++; if (done !== 3'b001 || result !== 24'h7FFFFF || result_sat !== 1'b1) $display("[TB] FAIL sat_capture got %b/%h/%b expected 001/7fffff/1", done, result, result_sat); else passCount++;
        req = 3'b000;
        repeat (2) tick();
        checkCount++; if (result !== 24'h7FFFFF || result_sat !== 1'b1 || done !== 3'b000) $display("[TB] FAIL sat_hold got %h/%b/%b expected 7fffff/1/000", result, result_sat, done); else passCount++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_flush();
        test_async_reset();
        test_saturation();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
